// File: rtl/soc_timer_bank_if.sv
// Port B device bus between the CPU data port and the timer bank.
interface soc_timer_bank_if;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic        data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;

    modport master (
        output addr_b, data_b_in, data_b_we,
        input  data_b, strobe_b
    );

    modport slave (
        input  addr_b, data_b_in, data_b_we,
        output data_b, strobe_b
    );
endinterface

// File: rtl/soc_timer_bank.sv
// Multi-channel down-counting timer bank with shared prescaler on the port B bus.
// Optional macro TIMER_REGISTERED_OUT_EN registers data_b/strobe_b (one-cycle read latency).
module soc_timer_bank #(
    parameter logic [31:0] BASE_ADDR = 32'd65560,
    parameter int          NCHAN     = 4,
    parameter int          CNT_WIDTH = 32,
    parameter int          PRE_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    soc_timer_bank_if.slave  bus,
    output logic [NCHAN-1:0] irq
);

    localparam logic [31:0] WIN_WORDS = 32'(4 * NCHAN + 1);
    localparam logic [31:0] PRESC_OFF = 32'(4 * NCHAN);

    logic [31:0] off;
    logic        in_win;
    logic        is_presc;
    logic        wr;
    logic [29:0] sel_ch;
    logic [1:0]  sel_reg;

    assign off      = bus.addr_b - BASE_ADDR;
    assign in_win   = (bus.addr_b >= BASE_ADDR) && (off < WIN_WORDS);
    assign is_presc = (off == PRESC_OFF);
    assign wr       = in_win && bus.data_b_we;
    assign sel_ch   = off[31:2];
    assign sel_reg  = off[1:0];

    logic [PRE_WIDTH-1:0] presc;
    logic [PRE_WIDTH-1:0] pc;
    logic                 tick;

    assign tick = (pc == presc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            pc    <= '0;
        end else if (wr && is_presc) begin
            presc <= bus.data_b_in[PRE_WIDTH-1:0];
            pc    <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PRE_WIDTH'(1);
        end
    end

    logic [NCHAN-1:0]     en;
    logic [NCHAN-1:0]     auto_rl;
    logic [NCHAN-1:0]     ie;
    logic [NCHAN-1:0]     expd;
    logic [CNT_WIDTH-1:0] count  [NCHAN];
    logic [CNT_WIDTH-1:0] period [NCHAN];

    logic [NCHAN-1:0] wr_ctrl;
    logic [NCHAN-1:0] wr_count;
    logic [NCHAN-1:0] wr_period;
    logic [NCHAN-1:0] wr_status;
    logic [NCHAN-1:0] expire;

    always_comb begin
        wr_ctrl   = '0;
        wr_count  = '0;
        wr_period = '0;
        wr_status = '0;
        expire    = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (wr && !is_presc && (sel_ch == 30'(i))) begin
                case (sel_reg)
                    2'd0:    wr_ctrl[i]   = 1'b1;
                    2'd1:    wr_count[i]  = 1'b1;
                    2'd2:    wr_period[i] = 1'b1;
                    default: wr_status[i] = 1'b1;
                endcase
            end
            expire[i] = tick && en[i] && (count[i] == '0);
        end
    end

    // Priorities: COUNT write beats decrement/reload, expiry set beats STATUS clear,
    // CTRL write beats the one-shot auto-disable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en      <= '0;
            auto_rl <= '0;
            ie      <= '0;
            expd    <= '0;
            irq     <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                count[i]  <= '0;
                period[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (wr_ctrl[i]) begin
                    en[i]      <= bus.data_b_in[0];
                    auto_rl[i] <= bus.data_b_in[1];
                    ie[i]      <= bus.data_b_in[2];
                end else if (expire[i] && !auto_rl[i]) begin
                    en[i] <= 1'b0;
                end

                if (wr_count[i]) begin
                    count[i] <= bus.data_b_in[CNT_WIDTH-1:0];
                end else if (tick && en[i]) begin
                    if (count[i] != '0)
                        count[i] <= count[i] - CNT_WIDTH'(1);
                    else if (auto_rl[i])
                        count[i] <= period[i];
                end

                if (wr_period[i])
                    period[i] <= bus.data_b_in[CNT_WIDTH-1:0];

                if (expire[i])
                    expd[i] <= 1'b1;
                else if (wr_status[i] && bus.data_b_in[0])
                    expd[i] <= 1'b0;

                irq[i] <= expd[i] & ie[i];
            end
        end
    end

    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (in_win) begin
            if (is_presc) begin
                rd_val = 32'(presc);
            end else begin
                for (int i = 0; i < NCHAN; i++) begin
                    if (sel_ch == 30'(i)) begin
                        case (sel_reg)
                            2'd0:    rd_val = {29'b0, ie[i], auto_rl[i], en[i]};
                            2'd1:    rd_val = 32'(count[i]);
                            2'd2:    rd_val = 32'(period[i]);
                            default: rd_val = {31'b0, expd[i]};
                        endcase
                    end
                end
            end
        end
    end

`ifdef TIMER_REGISTERED_OUT_EN
    logic [31:0] data_q;
    logic        strobe_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            data_q   <= rd_val;
            strobe_q <= in_win;
        end
    end

    assign bus.data_b   = data_q;
    assign bus.strobe_b = strobe_q;
`else
    assign bus.data_b   = rd_val;
    assign bus.strobe_b = in_win;
`endif

endmodule
